// File: rtl/data_mem_ctrl.sv
// Load/store data memory with byte/half/word access, lane merging, sign/zero
// extension, error detection and configurable-latency valid/ready handshakes.
module data_mem_ctrl #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg, uns_reg;
    logic [31:0]   addr_reg, wdata_reg;
    logic [1:0]    size_reg;
    logic [31:0]   resp_rdata_reg;
    logic          resp_err_reg;

    logic          accept, commit, err, wr_en;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, load_val, wr_bytes;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [3:0]    lane_we;
    logic [31:0]   mem_q [WORDS];

    assign req_ready  = (state_reg == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    // The counter is loaded so the commit edge lands exactly LATENCY edges after acceptance.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: if (accept) begin
                state_next = WAIT;
                cnt_next   = CW'(LATENCY - 1);
            end
            WAIT: if (cnt_reg == '0) begin
                state_next = RESP;
                commit     = 1'b1;
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            uns_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            size_reg       <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                size_reg  <= req_size;
            end
            if (commit) begin
                resp_err_reg   <= err;
                resp_rdata_reg <= (err || we_reg) ? '0 : load_val;
            end
        end
    end

    // Any address bit above the word index makes the request out of range.
    assign err = (size_reg == 2'b11)
               | ((size_reg == 2'b01) & addr_reg[0])
               | ((size_reg == 2'b10) & (addr_reg[1:0] != 2'b00))
               | (addr_reg[31:AW+2] != '0);

    assign word_idx = addr_reg[AW+1:2];
    assign rd_word  = mem_q[word_idx];
    assign byte_val = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    assign half_val = rd_word[{addr_reg[1], 4'b0000} +: 16];
    assign wr_en    = commit && we_reg && !err;

    always_comb begin
        load_val = rd_word;
        lane_we  = 4'b1111;
        wr_bytes = wdata_reg;
        case (size_reg)
            2'b00: begin
                load_val = {{24{~uns_reg & byte_val[7]}}, byte_val};
                lane_we  = 4'b0001 << addr_reg[1:0];
                wr_bytes = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                load_val = {{16{~uns_reg & half_val[15]}}, half_val};
                lane_we  = addr_reg[1] ? 4'b1100 : 4'b0011;
                wr_bytes = {2{wdata_reg[15:0]}};
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (word_idx == AW'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (lane_we[b]) word_reg[8*b +: 8] <= wr_bytes[8*b +: 8];
                    end
                end
            end
            assign mem_q[gi] = word_reg;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and random bench for data_mem_ctrl using a byte-addressed reference
// model and a queue of expected responses.
module tb_data_mem_ctrl;
    localparam int WORDS = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mbytes [4*WORDS];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [31:0] got;

    data_mem_ctrl #(.WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4*WORDS; i++) mbytes[i] = 8'h00;
    endtask

    // Reference behaviour, byte addressed, applied at issue time.
    function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [1:0] size,
                                          input logic uns);
        exp_t e;
        int   nb;
        logic [31:0] v;
        e.rdata = '0;
        e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(4*WORDS));
        if (e.err) return e;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (we) begin
            for (int i = 0; i < nb; i++) mbytes[addr + 32'(i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mbytes[addr + 32'(i)];
            if (!uns && size == 2'd0 && v[7])  v[31:8]  = '1;
            if (!uns && size == 2'd1 && v[15]) v[31:16] = '1;
            e.rdata = v;
        end
        return e;
    endfunction

    // One full request/response; called and returning at a falling edge.
    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns, input int stall,
                            output logic [31:0] rdata_out);
        exp_t e;
        int   cyc;
        logic busy_ready;
        logic [31:0] hold_rdata;
        logic        hold_err;
        sb_q.push_back(model_access(we, addr, wdata, size, uns));
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
        cyc = 0;
        while (!req_ready && cyc < 10) begin @(negedge clk); cyc++; end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = ~uns;
        cyc = 1; busy_ready = 1'b0;
        while (!resp_valid && cyc < 20) begin
            busy_ready |= req_ready;
            @(negedge clk); cyc++;
        end
        busy_ready |= req_ready;
        check("latency", 32'(cyc), 32'(LAT + 1));
        check("req_ready_busy", {31'd0, busy_ready}, 32'd0);
        hold_rdata = resp_rdata; hold_err = resp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, hold_rdata);
            check("stall_err", {31'd0, resp_err}, {31'd0, hold_err});
        end
        e = sb_q.pop_front();
        check("rdata", resp_rdata, e.rdata);
        check("err", {31'd0, resp_err}, {31'd0, e.err});
        rdata_out = resp_rdata;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("ready_after_hs", {31'd0, req_ready}, 32'd1);
        check("valid_after_hs", {31'd0, resp_valid}, 32'd0);
        $display("txn we=%0d addr=%08h size=%0d uns=%0d -> rdata=%08h err=%0d",
                 we, addr, size, uns, rdata_out, resp_err);
    endtask

    initial begin
        logic busy;
        model_clear();
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset clears memory
        transact(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, got);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_clear();
        @(negedge clk);
        transact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, got);
        check("tp_reset_load", got, 32'h00000000);

        // Byte merge and extension
        transact(1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 0, got);
        transact(1'b1, 32'h21, 32'hFFFFFF80, 2'd0, 1'b0, 0, got);
        transact(1'b0, 32'h20, 32'h0, 2'd2, 1'b1, 0, got);
        check("tp_merge_word", got, 32'h11228044);
        transact(1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 0, got);
        check("tp_byte_signed", got, 32'hFFFFFF80);
        transact(1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, got);
        check("tp_byte_unsigned", got, 32'h00000080);
        transact(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, got);
        check("tp_half_signed", got, 32'h00001122);
        transact(1'b1, 32'h26, 32'h0000BEEF, 2'd1, 1'b0, 0, got);
        transact(1'b0, 32'h26, 32'h0, 2'd1, 1'b0, 0, got);
        check("half_hi_signed", got, 32'hFFFFBEEF);

        // Errors leave memory untouched
        transact(1'b1, 32'h0, 32'hA5A55A5A, 2'd2, 1'b0, 0, got);
        transact(1'b1, 32'h06, 32'h12345678, 2'd2, 1'b0, 0, got);
        transact(1'b0, 32'h03, 32'h0, 2'd1, 1'b0, 0, got);
        transact(1'b1, 32'h0, 32'hFFFFFFFF, 2'd3, 1'b0, 0, got);
        transact(1'b1, 32'h400, 32'h87654321, 2'd2, 1'b0, 0, got);
        transact(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, got);
        transact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, got);
        check("tp_err_mem0", got, 32'hA5A55A5A);
        transact(1'b0, 32'h04, 32'h0, 2'd2, 1'b0, 0, got);
        check("tp_err_mem4", got, 32'h00000000);

        // Long response stall
        transact(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 5, got);

        // Reset one cycle after acceptance drops the store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
        req_wdata = 32'hCAFEF00D; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; model_clear();
        busy = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); busy |= resp_valid; end
        check("midrst_no_resp", {31'd0, busy}, 32'd0);
        check("midrst_rdata", resp_rdata, 32'd0);
        transact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, got);
        check("tp_midrst_load", got, 32'h00000000);

        // Random legal traffic
        for (int n = 0; n < 64; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 15)) * 4;
            if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
            if (sz == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
            transact(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom_range(0, 3), got);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
